// File: rtl/axis_pkg.sv
// Shared AXI-stream arbitration definitions: FSM encoding, skid depth and a
// reusable round-robin first-set search.
package axis_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int RR_MAX_REQ = 8;

  // First set bit of req[n-1:0], searching ptr, ptr+1, ... and wrapping modulo n.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int n);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!found && (i < n) && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry FIFO skid buffer: full-rate AXI-stream pass-through with a
// registered master side.
module axis_skid_buf
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  axis_aclk_i,
  input  logic                  axis_aresetn_i,
  input  logic                  s_axis_tvalid_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  output logic                  s_axis_tready_o,
  output logic                  m_axis_tvalid_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  input  logic                  m_axis_tready_i
);

  localparam logic [1:0] FULL_CNT = 2'(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_push;
  logic                  w_pop;

  assign s_axis_tready_o = (r_count != FULL_CNT);
  assign m_axis_tvalid_o = (r_count != 2'd0);
  assign m_axis_tdata_o  = r_mem[r_rd_ptr];
  assign w_push          = s_axis_tvalid_i && s_axis_tready_o;
  assign w_pop           = m_axis_tvalid_o && m_axis_tready_i;

  // Storage, pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge axis_aclk_i) begin
    if (!axis_aresetn_i) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= s_axis_tdata_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-stream slave between NUM_M masters,
// with bounded bursts per grant and a skid-buffered output.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int NUM_M      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                        axis_aclk_i,
  input  logic                        axis_aresetn_i,
  input  logic [NUM_M-1:0]            s_axis_tvalid_i,
  input  logic [NUM_M*DATA_WIDTH-1:0] s_axis_tdata_i,
  output logic [NUM_M-1:0]            s_axis_tready_o,
  output logic                        m_axis_tvalid_o,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata_o,
  input  logic                        m_axis_tready_i,
  output logic [NUM_M-1:0]            grant_o,
  output logic                        busy_o
);

  localparam int               PTR_W     = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [7:0]       LAST_BEAT = 8'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_M - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_gidx;
  logic [PTR_W-1:0]      w_pick;
  logic [PTR_W-1:0]      w_next_ptr;
  logic [7:0]            r_beat_cnt;
  logic [NUM_M-1:0]      r_grant;
  logic [NUM_M-1:0]      w_tready;
  logic                  w_req_any;
  logic                  w_gvalid;
  logic                  w_offer;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_exit;
  logic                  w_skid_ready;
  logic                  w_skid_valid;
  logic [DATA_WIDTH-1:0] w_gdata;

  assign w_req_any  = |s_axis_tvalid_i;
  assign w_pick     = PTR_W'(rr_pick(8'(s_axis_tvalid_i), 3'(r_rr_ptr), NUM_M));
  assign w_gvalid   = s_axis_tvalid_i[r_gidx];
  assign w_gdata    = s_axis_tdata_i[r_gidx*DATA_WIDTH +: DATA_WIDTH];
  assign w_offer    = (r_state == ST_GRANT) && w_gvalid;
  assign w_accept   = w_offer && w_skid_ready;
  assign w_last     = w_accept && (r_beat_cnt == LAST_BEAT);
  // A stalled beat keeps the grant; only release or the final beat end it.
  assign w_exit     = (r_state == ST_GRANT) && (!w_gvalid || w_last);
  assign w_next_ptr = (r_gidx == LAST_IDX) ? '0 : r_gidx + PTR_W'(1);

  assign s_axis_tready_o = w_tready;
  assign grant_o         = r_grant;
  assign busy_o          = (r_state == ST_GRANT) || w_skid_valid;
  assign m_axis_tvalid_o = w_skid_valid;

  // FSM state register.
  always_ff @(posedge axis_aclk_i) begin
    if (!axis_aresetn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_state_nxt = ST_GRANT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_exit) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_GRANT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: only the granted master sees the skid buffer's ready.
  always_comb begin
    w_tready = '0;
    if (r_state == ST_GRANT) begin
      w_tready[r_gidx] = w_skid_ready;
    end else begin
      w_tready = '0;
    end
  end

  // Grant bookkeeping: grant index, one-hot grant, beat count and rotation pointer.
  always_ff @(posedge axis_aclk_i) begin
    if (!axis_aresetn_i) begin
      r_rr_ptr   <= '0;
      r_gidx     <= '0;
      r_grant    <= '0;
      r_beat_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_gidx     <= w_pick;
            r_grant    <= NUM_M'(1) << w_pick;
            r_beat_cnt <= 8'd0;
          end
        end
        ST_GRANT: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
          end
          if (w_exit) begin
            r_rr_ptr <= w_next_ptr;
            r_grant  <= '0;
          end
        end
        default: begin
          r_grant <= '0;
        end
      endcase
    end
  end

  axis_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .axis_aclk_i     (axis_aclk_i),
    .axis_aresetn_i  (axis_aresetn_i),
    .s_axis_tvalid_i (w_offer),
    .s_axis_tdata_i  (w_gdata),
    .s_axis_tready_o (w_skid_ready),
    .m_axis_tvalid_o (w_skid_valid),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tready_i (m_axis_tready_i)
  );

endmodule
